// File: rtl/memory_arbiter.sv
// Serializes datapath instruction fetches and data loads/stores onto one variable-latency RAM.
// Data requests win, each completion yields a one-cycle ihit/dhit with registered load data.
module memory_arbiter #(
  parameter int DATA_W    = 32,
  parameter int RETRY_MAX = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [DATA_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [DATA_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] imemload,
  output logic [DATA_W-1:0] dmemload,
  output logic              err,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [DATA_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {IDLE, DATA, INSTR, DONE} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hBAD1BAD1);

  state_t            r_state, w_nextState;
  logic [DATA_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_store, w_store;
  logic              r_write, w_write;
  logic              r_gap, w_gap;
  logic [RW-1:0]     r_retry, w_retry;
  logic [RW-1:0]     w_retryInc;
  logic              r_ihit, w_ihit;
  logic              r_dhit, w_dhit;
  logic              r_err, w_err;
  logic [DATA_W-1:0] r_imemload, w_imemload;
  logic [DATA_W-1:0] r_dmemload, w_dmemload;
  logic              w_req;
  logic              w_strobe;
  logic              w_complete;
  logic [DATA_W-1:0] w_word;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_store    <= '0;
      r_write    <= 1'b0;
      r_gap      <= 1'b0;
      r_retry    <= '0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_err      <= 1'b0;
      r_imemload <= '0;
      r_dmemload <= '0;
    end else begin
      r_state    <= w_nextState;
      r_addr     <= w_addr;
      r_store    <= w_store;
      r_write    <= w_write;
      r_gap      <= w_gap;
      r_retry    <= w_retry;
      r_ihit     <= w_ihit;
      r_dhit     <= w_dhit;
      r_err      <= w_err;
      r_imemload <= w_imemload;
      r_dmemload <= w_dmemload;
    end
  end

  assign w_retryInc = r_retry + RW'(1);
  assign w_req = (r_state == DATA) ? (dmemREN | dmemWEN) : imemREN;

  always_comb begin
    w_nextState = r_state;
    w_addr      = r_addr;
    w_store     = r_store;
    w_write     = r_write;
    w_gap       = 1'b0;
    w_retry     = r_retry;
    w_ihit      = 1'b0;
    w_dhit      = 1'b0;
    w_err       = 1'b0;
    w_imemload  = r_imemload;
    w_dmemload  = r_dmemload;
    w_complete  = 1'b0;
    w_word      = ramload;

    case (r_state)
      IDLE: begin
        if (dmemREN | dmemWEN) begin
          w_addr      = dmemaddr;
          w_store     = dmemstore;
          w_write     = dmemWEN;
          w_nextState = DATA;
        end else if (imemREN) begin
          w_addr      = imemaddr;
          w_write     = 1'b0;
          w_nextState = INSTR;
        end
      end
      DATA, INSTR: begin
        // A dropped request aborts silently; the retry gap cycle ignores the RAM entirely.
        if (!w_req) begin
          w_nextState = IDLE;
          w_retry     = '0;
        end else if (!r_gap) begin
          if (ramstate == RAM_ACCESS) begin
            w_complete = 1'b1;
          end else if (ramstate == RAM_ERROR) begin
            w_retry = w_retryInc;
            if (w_retryInc == RW'(RETRY_MAX)) begin
              w_complete = 1'b1;
              w_word     = ERR_WORD;
              w_err      = 1'b1;
            end else begin
              w_gap = 1'b1;
            end
          end
        end
        if (w_complete) begin
          w_nextState = DONE;
          if (r_state == DATA) begin
            w_dhit = 1'b1;
            if (!r_write) w_dmemload = w_word;
          end else begin
            w_ihit     = 1'b1;
            w_imemload = w_word;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
        w_retry     = '0;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_strobe = ((r_state == DATA) || (r_state == INSTR)) && !r_gap;
  assign ramREN   = w_strobe && !r_write;
  assign ramWEN   = w_strobe && r_write && (r_state == DATA);
  assign ramaddr  = w_strobe ? r_addr : '0;
  assign ramstore = ramWEN ? r_store : '0;

  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign err      = r_err;
  assign imemload = r_imemload;
  assign dmemload = r_dmemload;

endmodule
